rob_ar_arbiter: RTL



---
 rtl/rob_arb_pkg.sv | 22 ++
 rtl/rr_arbiter.sv | 48 ++++
 rtl/rob_ar_arbiter.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/rob_arb_pkg.sv
// Shared types and defaults for the reorder-buffer AR arbiter (rob_ar_arbiter).
package rob_arb_pkg;

  localparam int unsigned ROB_ID_WIDTH   = 4;
  localparam int unsigned ROB_DATA_WIDTH = 8;

  // Entry fields are sized for the largest supported configuration (8 requesters, 8-bit count).
  localparam int unsigned OWN_W     = 3;
  localparam int unsigned CNT_MAX_W = 8;

  typedef enum logic [0:0] {IDLE, BUSY} arb_state_t;

  typedef struct packed {
    logic [OWN_W-1:0]     owner;
    logic [CNT_MAX_W-1:0] cnt;
  } own_entry_t;

  function automatic logic [CNT_MAX_W-1:0] cnt_max(input int unsigned width);
    return CNT_MAX_W'((1 << width) - 1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant, priority pointer moves past the winner on adv_i.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               adv_i,
  output logic [NUM_REQ-1:0] gnt_o
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] cur, win;
  logic             found;
  int unsigned      sum;
  int unsigned      nxt;

  always_comb begin
    gnt_o = '0;
    win   = ptr_q;
    found = 1'b0;
    sum   = 0;
    cur   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      sum = 32'(ptr_q) + i;
      if (sum >= NUM_REQ) sum = sum - NUM_REQ;
      cur = IDX_W'(sum);
      if (!found && req_i[cur]) begin
        found      = 1'b1;
        gnt_o[cur] = 1'b1;
        win        = cur;
      end
    end
    nxt   = 32'(win) + 1;
    ptr_d = ptr_q;
    if (adv_i && found) begin
      ptr_d = (nxt >= NUM_REQ) ? '0 : IDX_W'(nxt);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/rob_ar_arbiter.sv
// Shares one reorder buffer between NUM_REQ requesters: round-robin AR, per-ID R steering.
// Define ROB_ARB_ERR_EN to add err_o and swallow R beats for IDs with nothing outstanding.
module rob_ar_arbiter
  import rob_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned ID_WIDTH   = ROB_ID_WIDTH,
  parameter int unsigned DATA_WIDTH = ROB_DATA_WIDTH,
  parameter int unsigned CNT_WIDTH  = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ*ID_WIDTH-1:0]  s_arid_i,
  input  logic [NUM_REQ-1:0]           s_arvalid_i,
  output logic [NUM_REQ-1:0]           s_arready_o,
  output logic [DATA_WIDTH-1:0]        s_rdata_o,
  output logic [ID_WIDTH-1:0]          s_rid_o,
  output logic [NUM_REQ-1:0]           s_rvalid_o,
  input  logic [NUM_REQ-1:0]           s_rready_i,
  output logic [ID_WIDTH-1:0]          m_arid_o,
  output logic                         m_arvalid_o,
  input  logic                         m_arready_i,
  input  logic [DATA_WIDTH-1:0]        m_rdata_i,
  input  logic [ID_WIDTH-1:0]          m_rid_i,
  input  logic                         m_rvalid_i,
  output logic                         m_rready_o
`ifdef ROB_ARB_ERR_EN
  ,
  output logic                         err_o
`endif
);

  localparam int unsigned         NUM_ID  = 1 << ID_WIDTH;
  localparam logic [CNT_MAX_W-1:0] CNT_MAX = cnt_max(CNT_WIDTH);

  arb_state_t          state_q, state_d;
  logic [ID_WIDTH-1:0] m_arid_q, m_arid_d;
  own_entry_t          own_q [NUM_ID];
  own_entry_t          own_d [NUM_ID];

  logic [ID_WIDTH-1:0] req_id [NUM_REQ];
  logic [NUM_REQ-1:0]  eligible, arb_req, gnt;
  logic                ar_hs;
  logic [ID_WIDTH-1:0] win_id;
  logic [OWN_W-1:0]    win_idx;

  own_entry_t          r_entry;
  logic                r_known;
  logic [OWN_W-1:0]    r_owner;
  logic                r_hs, r_dec;

  // An ID may only be issued by its current owner, or by anyone once it has drained.
  always_comb begin
    eligible = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      req_id[k]   = s_arid_i[k*ID_WIDTH +: ID_WIDTH];
      eligible[k] = s_arvalid_i[k] &&
                    ((own_q[req_id[k]].cnt == '0) ||
                     ((own_q[req_id[k]].owner == OWN_W'(k)) && (own_q[req_id[k]].cnt < CNT_MAX)));
    end
    arb_req = (state_q == IDLE && !rst) ? eligible : '0;
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .clk   (clk),
    .rst   (rst),
    .req_i (arb_req),
    .adv_i (ar_hs),
    .gnt_o (gnt)
  );

  always_comb begin
    ar_hs   = |gnt;
    win_id  = '0;
    win_idx = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (gnt[k]) begin
        win_id  = req_id[k];
        win_idx = OWN_W'(k);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    m_arid_d = m_arid_q;
    unique case (state_q)
      IDLE: begin
        if (ar_hs) begin
          m_arid_d = win_id;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        if (m_arready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign s_arready_o = gnt;
  assign m_arvalid_o = (state_q == BUSY);
  assign m_arid_o    = m_arid_q;

  // R steering; a drained ID has no meaningful owner, so it falls back to requester 0.
  always_comb begin
    r_entry    = own_q[m_rid_i];
    r_known    = (r_entry.cnt != '0);
    r_owner    = r_known ? r_entry.owner : '0;
    s_rvalid_o = '0;
    m_rready_o = 1'b0;
    s_rdata_o  = '0;
    s_rid_o    = '0;
    if (!rst) begin
      s_rdata_o = m_rdata_i;
      s_rid_o   = m_rid_i;
`ifdef ROB_ARB_ERR_EN
      if (!r_known) begin
        m_rready_o = 1'b1;
      end else begin
`else
      begin
`endif
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
          if (r_owner == OWN_W'(k)) begin
            s_rvalid_o[k] = m_rvalid_i;
            m_rready_o    = s_rready_i[k];
          end
        end
      end
    end
    r_hs  = m_rvalid_i && m_rready_o;
    r_dec = r_hs && r_known;
  end

  // Same-cycle issue and retire on one ID leaves the count unchanged.
  always_comb begin
    own_d = own_q;
    if (r_dec) begin
      own_d[m_rid_i].cnt = own_q[m_rid_i].cnt - 1'b1;
    end
    if (ar_hs) begin
      own_d[win_id].owner = win_idx;
      own_d[win_id].cnt   = (r_dec && (m_rid_i == win_id)) ? own_q[win_id].cnt
                                                           : own_q[win_id].cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      m_arid_q <= '0;
      for (int unsigned e = 0; e < NUM_ID; e++) begin
        own_q[e] <= '0;
      end
    end else begin
      state_q  <= state_d;
      m_arid_q <= m_arid_d;
      own_q    <= own_d;
    end
  end

`ifdef ROB_ARB_ERR_EN
  logic err_q, err_d;

  assign err_d = err_q | (r_hs && !r_known);
  assign err_o = err_q;

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end
`endif

endmodule
